// File: rtl/scan_decoder_n.sv
// rtl/scan_decoder_n.sv - registered active-low one-of-N scan/select decoder
//
// Purpose:
//    Drives display digit/row selects. Either decodes an external channel
//    number (direct mode) or walks all N = 2**SEL_W channels on its own
//    (auto-scan mode), spending DIV clocks on each channel.
//
// Parameters:
//    SEL_W  select/index width, N = 2**SEL_W output lines (>= 1)
//    DIV    scan-mode clocks per channel (>= 1, >= 2 with SCAN_BLANK_EN)
//
// Optional feature:
//    SCAN_BLANK_EN  when defined, every scan advance inserts one all-ones
//                   (blank) cycle ahead of the new channel to suppress
//                   ghosting; the scan period stays N*DIV.
//
// Ports:
//    clk   in   rising-edge clock
//    rst   in   asynchronous active-high reset
//    en    in   active-low enable (1 = all selects deasserted, state frozen)
//    mode  in   0 = direct decode of sel, 1 = auto-scan
//    sel   in   channel to decode in direct mode
//    b     out  registered active-low one-hot select, all ones = none
//    idx   out  registered index of the channel decoded/scanned
//    wrap  out  one-cycle pulse when the scan index wraps N-1 -> 0

module scan_decoder_n #(
   parameter int SEL_W = 2,
   parameter int DIV   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [(2**SEL_W)-1:0]   b,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int N  = 2**SEL_W;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

   logic [PW-1:0]    presc;
   logic [PW-1:0]    presc_n;
   logic [N-1:0]     b_n;
   logic [SEL_W-1:0] idx_n;
   logic             wrap_n;
   // lit = the select outputs currently show a channel. It is cleared by
   // reset and by en=1; the edge that relights the outputs does not advance
   // the prescaler, so a channel resumed after a freeze (or the first
   // channel after reset) still gets its full remaining dwell on the pads.
   logic             lit;
   logic             lit_n;

   function automatic logic [N-1:0] onecold(input logic [SEL_W-1:0] i);
      onecold = ~(N'(1) << i);
   endfunction

   always_comb begin
      b_n     = b;
      idx_n   = idx;
      presc_n = presc;
      wrap_n  = 1'b0;
      lit_n   = lit;
      if (en) begin
         // disabled: blank the pads, freeze idx and prescaler
         b_n   = '1;
         lit_n = 1'b0;
      end else if (!mode) begin
         idx_n   = sel;
         b_n     = onecold(sel);
         presc_n = '0;
         lit_n   = 1'b1;
      end else if (!lit) begin
         b_n   = onecold(idx);
         lit_n = 1'b1;
      end else if (presc == PLAST) begin
         presc_n = '0;
         idx_n   = idx + SEL_W'(1);
         wrap_n  = (idx == {SEL_W{1'b1}});
`ifdef SCAN_BLANK_EN
         b_n     = '1;
`else
         b_n     = onecold(idx + SEL_W'(1));
`endif
      end else begin
         // also relights the channel on the cycle after a blank advance
         presc_n = presc + PW'(1);
         b_n     = onecold(idx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b     <= '1;
         idx   <= '0;
         presc <= '0;
         wrap  <= 1'b0;
         lit   <= 1'b0;
      end else begin
         b     <= b_n;
         idx   <= idx_n;
         presc <= presc_n;
         wrap  <= wrap_n;
         lit   <= lit_n;
      end
   end

endmodule

// File: tb/tb_scan_decoder_n.sv
// tb/tb_scan_decoder_n.sv - self-checking bench for scan_decoder_n

module tb_scan_decoder_n;

   localparam int SEL_W = 2;
   localparam int DIV   = 3;
   localparam int N     = 4;
`ifdef SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       en   = 1'b0;
   logic       mode = 1'b0;
   logic [1:0] sel  = 2'd0;
   logic [3:0] b;
   logic [1:0] idx;
   logic       wrap;

   always #5 clk = ~clk;

   scan_decoder_n #(.SEL_W(SEL_W), .DIV(DIV)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .sel  (sel),
      .b    (b),
      .idx  (idx),
      .wrap (wrap)
   );

   int checks   = 0;
   int failures = 0;

   // reference model: channel index, cycles already spent on the channel,
   // whether the pads currently show a channel, and the expected outputs
   int m_idx;
   int m_dwell;
   bit m_on;
   int m_b;
   bit m_wrap;

   logic [3:0] exp_scan [13];

   function automatic int sel_code(input int i);
      return (1 << N) - 1 - (1 << i);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx   = 0;
      m_dwell = 0;
      m_on    = 1'b0;
      m_b     = (1 << N) - 1;
      m_wrap  = 1'b0;
   endtask

   task automatic model_edge();
      m_wrap = 1'b0;
      if (en) begin
         m_on = 1'b0;
         m_b  = (1 << N) - 1;
      end else if (!mode) begin
         m_idx   = int'(sel);
         m_dwell = 0;
         m_on    = 1'b1;
         m_b     = sel_code(m_idx);
      end else if (!m_on) begin
         m_on = 1'b1;
         m_b  = sel_code(m_idx);
      end else begin
         m_dwell++;
         if (m_dwell == DIV) begin
            m_dwell = 0;
            m_wrap  = (m_idx == N - 1);
            m_idx   = (m_idx + 1) % N;
            m_b     = BLANK ? (1 << N) - 1 : sel_code(m_idx);
         end else begin
            m_b = sel_code(m_idx);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check("model_b", 32'(b), 32'(m_b));
      check("model_idx", 32'(idx), 32'(m_idx));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
   endtask

   // called at posedge+1: assert rst between edges and check it acts at once
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst_b", 32'(b), 32'hf);
      check("async_rst_idx", 32'(idx), 32'h0);
      check("async_rst_wrap", 32'(wrap), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      if (BLANK)
         exp_scan = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1111,
                      4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
      else
         exp_scan = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b1011,
                      4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_b", 32'(b), 32'hf);
      check("rst_idx", 32'(idx), 32'h0);
      check("rst_wrap", 32'(wrap), 32'h0);

      // scan sequence from reset
      mode = 1'b1;
      en   = 1'b0;
      rst  = 1'b0;
      for (int i = 0; i < 13; i++) begin
         step();
         check("scan_b", 32'(b), 32'(exp_scan[i]));
         check("scan_wrap", 32'(wrap), (i == 12) ? 32'h1 : 32'h0);
      end

      // reach idx=1 with prescaler=1, then freeze for 5 cycles
      repeat (4) step();
      check("pre_freeze_b", 32'(b), 32'hd);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("freeze_b", 32'(b), 32'hf);
         check("freeze_idx", 32'(idx), 32'h1);
      end
      en = 1'b0;
      step();
      check("resume_b0", 32'(b), 32'hd);
      step();
      check("resume_b1", 32'(b), 32'hd);
      step();
      check("resume_b2", 32'(b), BLANK ? 32'hf : 32'hb);
      check("resume_idx2", 32'(idx), 32'h2);

      // run on to idx=3, then switch to direct with sel=0
      repeat (3) step();
      check("pre_switch_idx", 32'(idx), 32'h3);
      mode = 1'b0;
      sel  = 2'd0;
      step();
      check("switch_b", 32'(b), 32'he);
      check("switch_idx", 32'(idx), 32'h0);
      check("switch_wrap", 32'(wrap), 32'h0);
      mode = 1'b1;
      step();
      check("rescan_b0", 32'(b), 32'he);
      step();
      check("rescan_b1", 32'(b), 32'he);
      step();
      check("rescan_b2", 32'(b), BLANK ? 32'hf : 32'hd);

      // direct decode
      mode = 1'b0;
      sel  = 2'b10;
      step();
      check("direct_b2", 32'(b), 32'hb);
      check("direct_idx2", 32'(idx), 32'h2);
      sel = 2'b11;
      step();
      check("direct_b3", 32'(b), 32'h7);
      check("direct_idx3", 32'(idx), 32'h3);

      // reset mid-scan
      mode = 1'b1;
      repeat (4) step();
      async_reset();
      step();
      check("post_rst_b", 32'(b), 32'he);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0)
            async_reset();
         en = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0)
            mode = ~mode;
         sel = 2'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
